// File: rtl/inst_cache.sv
// rtl/inst_cache.sv - direct-mapped read-only instruction cache with burst line fill
//
// Purpose: serves one INST_WIDTH word per fetcher request. Hits answer in the
// next cycle; misses fetch the whole line from the memory controller as an
// in-order burst (word 0 first), install it, and forward the requested word.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   rdy             global enable; when low, every register and array holds
//   read_valid      fetcher request strobe, sampled only in IDLE
//   read_addr       byte address of the requested word (bits [1:0] ignored)
//   read_done       one-cycle pulse, read_data carries the requested word
//   read_data       requested word, held until the next read_done
//   mem_req_valid   line-fill request pending
//   mem_req_addr    line-aligned fill address
//   mem_req_ready   controller accepts the request (valid && ready)
//   mem_resp_valid  one fill word present on mem_resp_data
//   mem_resp_data   fill word, arriving in ascending word order

module inst_cache #(
  parameter int ADDR_WIDTH   = 17,
  parameter int INST_WIDTH   = 32,
  parameter int INDEX_WIDTH  = 6,
  parameter int OFFSET_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  read_valid,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic                  read_done,
  output logic [INST_WIDTH-1:0] read_data,
  output logic                  mem_req_valid,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_req_ready,
  input  logic                  mem_resp_valid,
  input  logic [INST_WIDTH-1:0] mem_resp_data
);

  localparam int TAG_WIDTH      = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int WORD_BITS      = OFFSET_WIDTH - 2;
  localparam int WORDS_PER_LINE = 1 << WORD_BITS;
  localparam int LINES          = 1 << INDEX_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEM_REQ,
    S_MEM_RESP,
    S_RESP
  } state_t;

  state_t state, state_next;

  // Storage: valid bits are reset, tags and data are not.
  logic [LINES-1:0]      valid_q;
  logic [TAG_WIDTH-1:0]  tag_mem  [LINES];
  logic [INST_WIDTH-1:0] data_mem [LINES][WORDS_PER_LINE];

  // Words 0..WORDS_PER_LINE-2 of a fill park here; the last word goes
  // straight from mem_resp_data into the array on the final beat.
  logic [INST_WIDTH-1:0] line_buf [WORDS_PER_LINE];
  logic [WORD_BITS-1:0]  word_cnt;

  // Latched word address of the request being served (byte lane dropped).
  logic [ADDR_WIDTH-1:2] req_addr;

  logic [TAG_WIDTH-1:0]   in_tag;
  logic [INDEX_WIDTH-1:0] in_index;
  logic [WORD_BITS-1:0]   in_word;
  logic [TAG_WIDTH-1:0]   req_tag;
  logic [INDEX_WIDTH-1:0] req_index;
  logic [WORD_BITS-1:0]   req_word;
  logic                   addr_lsb_unused;

  assign in_tag    = read_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign in_index  = read_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign in_word   = read_addr[2 +: WORD_BITS];
  assign req_tag   = req_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign req_index = req_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign req_word  = req_addr[2 +: WORD_BITS];

  // The byte lane within a word carries no information for a word fetch.
  assign addr_lsb_unused = ^read_addr[1:0];

  // Control strobes, decoded from the current state and inputs.
  logic accept_hit;
  logic accept_miss;
  logic req_fire;
  logic beat;
  logic last_beat;

  always_comb begin
    state_next  = state;
    accept_hit  = 1'b0;
    accept_miss = 1'b0;
    req_fire    = 1'b0;
    beat        = 1'b0;
    last_beat   = 1'b0;
    case (state)
      S_IDLE: begin
        if (read_valid) begin
          if (valid_q[in_index] && (tag_mem[in_index] == in_tag)) begin
            accept_hit = 1'b1;
            state_next = S_RESP;
          end else begin
            accept_miss = 1'b1;
            state_next  = S_MEM_REQ;
          end
        end
      end
      S_MEM_REQ: begin
        if (mem_req_ready) begin
          req_fire   = 1'b1;
          state_next = S_MEM_RESP;
        end
      end
      S_MEM_RESP: begin
        if (mem_resp_valid) begin
          beat = 1'b1;
          if (word_cnt == '1) begin
            last_beat  = 1'b1;
            state_next = S_RESP;
          end
        end
      end
      S_RESP: begin
        // read_valid is deliberately not sampled here so a request held
        // across the done pulse is served only once.
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else if (rdy) begin
      state <= state_next;
    end
  end

  // Control registers and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q       <= '0;
      read_done     <= 1'b0;
      read_data     <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      word_cnt      <= '0;
      req_addr      <= '0;
    end else if (rdy) begin
      read_done <= 1'b0;
      if (accept_hit || accept_miss) begin
        req_addr <= read_addr[ADDR_WIDTH-1:2];
      end
      if (accept_hit) begin
        read_done <= 1'b1;
        read_data <= data_mem[in_index][in_word];
      end
      if (accept_miss) begin
        mem_req_valid <= 1'b1;
        mem_req_addr  <= {in_tag, in_index, {OFFSET_WIDTH{1'b0}}};
      end
      if (req_fire) begin
        mem_req_valid <= 1'b0;
        word_cnt      <= '0;
      end
      if (beat) begin
        word_cnt <= word_cnt + 1'b1;
      end
      if (last_beat) begin
        // The line only becomes valid once every word is in hand.
        valid_q[req_index] <= 1'b1;
        read_done          <= 1'b1;
        read_data          <= (req_word == '1) ? mem_resp_data : line_buf[req_word];
      end
    end
  end

  // Line buffer and array writes; no reset needed, gated by valid_q.
  always_ff @(posedge clk) begin
    if (!rst && rdy && beat) begin
      line_buf[word_cnt] <= mem_resp_data;
      if (last_beat) begin
        tag_mem[req_index] <= req_tag;
        for (int w = 0; w < WORDS_PER_LINE - 1; w++) begin
          data_mem[req_index][w[WORD_BITS-1:0]] <= line_buf[w[WORD_BITS-1:0]];
        end
        data_mem[req_index][WORDS_PER_LINE-1] <= mem_resp_data;
      end
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// tb/tb_inst_cache.sv - self-checking bench for inst_cache

module tb_inst_cache;

  localparam int AW = 17;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          rdy;
  logic          read_valid;
  logic [AW-1:0] read_addr;
  logic          read_done;
  logic [IW-1:0] read_data;
  logic          mem_req_valid;
  logic [AW-1:0] mem_req_addr;
  logic          mem_req_ready;
  logic          mem_resp_valid;
  logic [IW-1:0] mem_resp_data;

  inst_cache dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .read_valid    (read_valid),
    .read_addr     (read_addr),
    .read_done     (read_done),
    .read_data     (read_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Backing memory contents: line 0 holds 0x13, 0x00100093, 0x00200113, 0x00300193.
  function automatic logic [31:0] mem_val(input logic [AW-1:0] a);
    return 32'h0000_0013 + 32'(a >> 2) * 32'h0010_0080;
  endfunction

  // Cache model: which line each index holds.
  bit         m_valid [64];
  logic [6:0] m_tag   [64];

  // Expectations shared with the monitor.
  bit            pending  = 1'b0;
  bit            exp_miss = 1'b0;
  logic [31:0]   exp_data = '0;
  logic [AW-1:0] exp_line = '0;

  // Memory controller responder state.
  int            phase       = 0;
  int            beats_taken = 0;
  int            wait_cnt    = 0;
  int            gap         = 0;
  int            ready_delay = 0;
  int            beat_gap    = 0;
  bit            junk_en     = 1'b0;
  logic [AW-1:0] fill_base   = '0;
  time           last4_time  = 0;
  time           t_edge      = 0;
  bit            s_rdy, s_rst, s_ready, s_respv;
  bit            s_reqv = 1'b0;

  initial begin
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    forever begin
      @(posedge clk);
      s_rdy   = rdy;
      s_rst   = rst;
      s_ready = mem_req_ready;
      s_respv = mem_resp_valid;
      t_edge  = $time;
      @(negedge clk);
      if (s_rst) begin
        phase       = 0;
        beats_taken = 0;
      end else if (s_rdy) begin
        if (phase == 1 && s_ready && s_reqv) begin
          phase       = 2;
          beats_taken = 0;
          gap         = 0;
        end else if (phase == 2 && s_respv) begin
          beats_taken++;
          gap = beat_gap;
          if (beats_taken == 4) begin
            phase      = 0;
            last4_time = t_edge;
          end
        end
      end
      s_reqv         = mem_req_valid;
      mem_req_ready  = junk_en && phase == 0;
      mem_resp_valid = junk_en && phase == 0;
      mem_resp_data  = 32'hDEAD_BEEF;
      if (phase == 0 && mem_req_valid) begin
        phase          = 1;
        wait_cnt       = ready_delay;
        fill_base      = mem_req_addr;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
      end
      if (phase == 1) begin
        if (wait_cnt == 0) mem_req_ready = 1'b1;
        else wait_cnt--;
      end
      if (phase == 2) begin
        if (gap == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = mem_val(fill_base + 17'(beats_taken * 4));
        end else begin
          gap--;
        end
      end
    end
  end

  // Per-cycle output monitor.
  bit          prev_rst  = 1'b1;
  bit          prev_done = 1'b0;
  logic [31:0] last_data = '0;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (prev_rst) begin
        chk("rst_done", 32'(read_done), 32'd0);
        chk("rst_data", read_data, 32'd0);
        chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
        last_data = '0;
      end else begin
        if (read_done) begin
          chk("done_while_pending", 32'(pending), 32'd1);
          chk("done_data", read_data, exp_data);
          chk("done_single_pulse", 32'(prev_done), 32'd0);
          last_data = exp_data;
        end else begin
          chk("data_hold", read_data, last_data);
        end
        if (mem_req_valid) begin
          chk("req_only_on_miss", 32'(exp_miss), 32'd1);
          chk("req_addr", 32'(mem_req_addr), 32'(exp_line));
        end
      end
      prev_done = read_done;
      prev_rst  = rst;
    end
  end

  task automatic do_read(input logic [AW-1:0] a, input bit exp_hit, input logic [31:0] lit,
                         input int rdelay, input int bgap, input int freeze_at, input int abort_at);
    logic [5:0] idx;
    logic [6:0] tg;
    bit         hit;
    bit         done;
    bit         frozen;
    bit         aborted;
    int         n;
    idx = a[9:4];
    tg  = a[16:10];
    hit = m_valid[idx] && (m_tag[idx] == tg);
    chk("model_hit", 32'(hit), 32'(exp_hit));
    ready_delay = rdelay;
    beat_gap    = bgap;
    exp_data    = mem_val(a);
    exp_line    = {a[16:4], 4'b0};
    exp_miss    = !hit;
    pending     = 1'b1;
    read_valid  = 1'b1;
    read_addr   = a;
    done        = 1'b0;
    frozen      = 1'b0;
    aborted     = 1'b0;
    n           = 0;
    while (!done && !aborted && n < 300) begin
      @(negedge clk);
      #1;
      n++;
      // The request is latched; a changing address must not matter now.
      if (n == 1) read_addr = ~a;
      if (read_done) begin
        done = 1'b1;
      end else if (freeze_at > 0 && !frozen && phase == 2 && beats_taken == freeze_at) begin
        rdy = 1'b0;
        repeat (4) begin
          @(negedge clk);
          #1;
          n++;
        end
        rdy    = 1'b1;
        frozen = 1'b1;
      end else if (abort_at > 0 && phase == 2 && beats_taken == abort_at) begin
        rst        = 1'b1;
        read_valid = 1'b0;
        pending    = 1'b0;
        exp_miss   = 1'b0;
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        repeat (2) begin
          @(negedge clk);
          #1;
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("post_rst_done", 32'(read_done), 32'd0);
        chk("post_rst_data", read_data, 32'd0);
        aborted = 1'b1;
      end
    end
    if (aborted) return;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL timeout: no read_done for address %h after %0d cycles", a, n);
      read_valid = 1'b0;
      pending    = 1'b0;
      return;
    end
    chk("read_data_lit", read_data, lit);
    if (hit) chk("hit_latency", 32'(n), 32'd1);
    else chk("miss_latency", 32'($time - last4_time), 32'd6);
    m_valid[idx] = 1'b1;
    m_tag[idx]   = tg;
    read_valid   = 1'b0;
    @(negedge clk);
    #1;
    chk("done_pulse_end", 32'(read_done), 32'd0);
    pending  = 1'b0;
    exp_miss = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    rdy        = 1'b1;
    read_valid = 1'b0;
    read_addr  = '0;
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("reset_read_done", 32'(read_done), 32'd0);
    chk("reset_read_data", read_data, 32'd0);
    chk("reset_req_valid", 32'(mem_req_valid), 32'd0);
    chk("reset_req_addr", 32'(mem_req_addr), 32'd0);
    rst = 1'b0;

    // Cold miss, hits in the installed line (word 1 and word 3).
    do_read(17'h00000, 1'b0, 32'h0000_0013, 0, 0, 0, 0);
    do_read(17'h00004, 1'b1, 32'h0010_0093, 0, 0, 0, 0);
    do_read(17'h0000C, 1'b1, 32'h0030_0193, 0, 0, 0, 0);

    // Conflict on index 0, then the evicted line misses again.
    do_read(17'h00400, 1'b0, 32'h1000_8013, 0, 0, 0, 0);
    do_read(17'h00000, 1'b0, 32'h0000_0013, 0, 0, 0, 0);

    // Backpressure on the request and gaps between beats.
    do_read(17'h00A28, 1'b0, 32'h28A1_4513, 3, 2, 0, 0);

    // Spurious ready/resp from the controller while not filling.
    junk_en = 1'b1;
    do_read(17'h00A24, 1'b1, 32'h2891_4493, 0, 0, 0, 0);

    // rdy freeze in the middle of a fill, word-3 forwarding path.
    do_read(17'h01F0C, 1'b0, 32'h7C33_E193, 0, 0, 2, 0);
    do_read(17'h01F00, 1'b1, 32'h7C03_E013, 0, 0, 0, 0);

    // Reset after two beats, then the same address must fully miss.
    do_read(17'h01238, 1'b0, 32'h0, 0, 0, 0, 2);
    do_read(17'h01238, 1'b0, 32'h48E2_4713, 0, 0, 0, 0);
    do_read(17'h01230, 1'b1, 32'h48C2_4613, 0, 0, 0, 0);
    do_read(17'h00004, 1'b0, 32'h0010_0093, 1, 1, 0, 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_cache.md
Name: inst_cache

Overview:
- Direct-mapped, read-only instruction cache between the memory controller and the instruction fetcher.
- Serves one 32-bit word per request from the fetcher.
- On a miss, fetches a full line from the memory controller as a burst of words, installs it, and forwards the requested word.
- Drives the fetcher's inst_cache_read_done / inst_cache_read_data inputs.

Parameters:
- ADDR_WIDTH, 17: byte address width.
- INST_WIDTH, 32: instruction/word width.
- INDEX_WIDTH, 6: line index bits; 64 lines.
- OFFSET_WIDTH, 4: byte offset bits; 16-byte lines, WORDS_PER_LINE = 4.
- Derived: TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH = 7.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- rdy  input  1  global enable; when 0, all state and outputs freeze.
- read_valid  input  1  fetcher requests a word at read_addr.
- read_addr  input  ADDR_WIDTH  byte address; bits [1:0] ignored.
- read_done  output  1  one-cycle pulse: read_data holds the requested word.
- read_data  output  INST_WIDTH  requested word; holds its value until the next read_done.
- mem_req_valid  output  1  line-fill request pending.
- mem_req_addr  output  ADDR_WIDTH  line-aligned address; low OFFSET_WIDTH bits are 0.
- mem_req_ready  input  1  memory controller accepts the request; transfer occurs on valid && ready.
- mem_resp_valid  input  1  one response word present.
- mem_resp_data  input  INST_WIDTH  response word; words arrive in order, word 0 first.

Behaviour:
- Address split: tag = addr[16:10], index = addr[9:4], word = addr[3:2].
- Storage: per line, one valid bit, a tag, and 4 words.
- Reset:
  - Clear all valid bits; state = IDLE.
  - read_done = 0, read_data = 0, mem_req_valid = 0, mem_req_addr = 0, word counter = 0.
  - Data arrays need not be cleared.
- rdy = 0: no state, array, counter or output changes. A memory handshake does not complete while rdy = 0; mem_resp_valid seen while rdy = 0 is dropped. The controller is paused by the same rdy.
- IDLE:
  - If read_valid: latch the address into req_addr. Later read_addr changes are ignored until return to IDLE.
  - Hit (line valid and tag match): next cycle read_done = 1, read_data = stored word; go to RESP.
  - Miss: next cycle mem_req_valid = 1, mem_req_addr = {tag, index, 0}; go to MEM_REQ.
  - If read_valid = 0: remain in IDLE, read_done = 0.
- MEM_REQ:
  - Hold mem_req_valid and mem_req_addr stable until mem_req_ready = 1.
  - On that cycle: mem_req_valid <= 0, counter <= 0, go to MEM_RESP.
- MEM_RESP:
  - Each cycle with mem_resp_valid: write mem_resp_data into the line buffer at the counter position; counter += 1 (2-bit, wraps).
  - On the 4th word, in one cycle:
    - Write the full line into the indexed entry; set its tag and valid bit.
    - read_done <= 1; read_data <= the requested word. If it is word 3, it is forwarded straight from mem_resp_data.
    - Go to RESP.
  - The line is not marked valid before all 4 words have arrived.
- RESP:
  - read_done = 1 for exactly this cycle, then drops to 0. Go to IDLE.
  - read_valid is not sampled in RESP, so a request held high across the done pulse is served once, not twice.
- Latency:
  - Hit: request accepted in cycle n, read_done in cycle n+1, next request accepted no earlier than n+2.
  - Miss: 1 cycle to raise mem_req_valid, plus the handshake wait, plus 4 response beats; read_done in the cycle after the 4th beat.
- Miss replacement: evicts the indexed line unconditionally; no write-back.
- Spurious inputs: mem_resp_valid outside MEM_RESP is ignored; mem_req_ready outside MEM_REQ is ignored.
- Reset mid-fill: the fill is abandoned and the partial line is never made valid. The memory controller is reset by the same rst.

Test Plan:
- Cold miss: after reset, read 0x00000; controller answers with 0x00000013, 0x00100093, 0x00200113, 0x00300193. Required: mem_req_addr = 0x00000; read_done one cycle after the 4th beat; read_data = 0x00000013.
- Hit: then read 0x00004. Required: read_done exactly 1 cycle after acceptance, read_data = 0x00100093, no mem_req_valid. Then read 0x0000C. Required: read_data = 0x00300193 (word-3 path).
- Conflict: read 0x00400 (same index 0, tag 1). Required: miss, mem_req_addr = 0x00400. Re-reading 0x00000 then misses again.
- Backpressure: mem_req_ready low for 3 cycles, and a 2-cycle gap between response beats. Required: mem_req_valid and mem_req_addr held stable throughout; correct word returned; read_done is a single-cycle pulse.
- rdy freeze: drop rdy for 4 cycles mid-MEM_RESP. Required: counter, outputs and array unchanged; fill completes correctly after rdy returns.
- Reset mid-fill: assert rst after 2 beats, then read the same address. Required: full miss with a new request, no stale hit, read_done = 0 during and right after reset.
